cache_controller: RTL
=====================

Name: cache_controller

Overview:
- Two-way set-associative, write-through, no-write-allocate word cache between the MEM stage and the SRAM controller.
- Read hits complete in the same cycle with no stall.
- Read misses, and all writes, issue a single-cycle request to the SRAM controller and hold `freeze` until it finishes.
- Hides the roughly 7-cycle SRAM access for repeated loads.

Parameters:
- SET_BITS, 6, log2 of the set count (64 sets); index = address[SET_BITS+1:2].
- WORD_ADDR_BITS, 17, word-address width passed to SRAM (address[18:2]); tag = address[18:SET_BITS+2] (11 bits at defaults).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- read  in  1  MEM-stage load request
- write  in  1  MEM-stage store request
- address  in  32  byte address; bits [1:0] and [31:19] ignored
- dataIn  in  32  store data
- dataOut  out  32  load data
- freeze  out  1  stall to the pipeline
- sramRead  out  1  read request to the SRAM controller
- sramWrite  out  1  write request to the SRAM controller
- sramAddress  out  32  address to the SRAM controller (the latched request address)
- sramDataIn  out  32  store data to the SRAM controller
- sramDataOut  in  32  load data from the SRAM controller
- sramFreeze  in  1  SRAM controller busy; low only when that controller is idle

Behaviour:
- Reset (async):
  - state = Idle; all valid bits and LRU bits = 0.
  - Outputs: freeze = 0, sramRead = 0, sramWrite = 0, dataOut = 0, sramAddress = 0, sramDataIn = 0.
- States: Idle, ReadIssue, ReadWait, WriteIssue, WriteWait.
- Priority: write beats read when both are high.
- Hit = valid && tag match in either way of the indexed set. At most one way hits; if both match, way 0 wins.
- Idle:
  - Read hit:
    - dataOut = hit-way data (combinational); freeze = 0.
    - LRU[set] <= the other way at the clock edge.
    - Stay in Idle.
  - Read miss:
    - freeze = 1; latch address.
    - Go to ReadIssue.
  - Write:
    - freeze = 1; latch address and dataIn.
    - On a hit, update the hit way's data and LRU at this edge. On a miss, leave the arrays untouched (no allocate).
    - Go to WriteIssue.
  - No request: freeze = 0; dataOut holds its last value.
- ReadIssue / WriteIssue:
  - Exactly one cycle; sramRead or sramWrite = 1 for that cycle only.
  - sramAddress / sramDataIn come from the latched values; freeze = 1.
  - Advance to the matching Wait state unconditionally.
- ReadWait / WriteWait:
  - sramRead = sramWrite = 0; freeze = 1 while sramFreeze = 1.
  - The first cycle with sramFreeze = 0 is the completion cycle: freeze = 0, next state Idle.
  - ReadWait completion only:
    - dataOut = sramDataOut.
    - Write sramDataOut, tag and valid = 1 into the victim way, then set LRU[set] = the other way.
    - Victim = the invalid way if any (way 0 first), else way LRU[set].
- Latency, with the current SRAM controller:
  - Read hit: 0 stall cycles.
  - Read miss or any write: freeze high for 7 cycles (Idle, Issue, 5 wait cycles); released in the 8th cycle.
- The request must never stay asserted into the controller's return-to-idle cycle; this single-cycle pulse is mandatory to prevent a re-issue.
- read / write deasserting during a miss is ignored; the transaction completes.
- A new request in the cycle after completion is handled normally from Idle.
- Reset mid-transaction abandons it; cache contents are invalidated.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds output ports hitCount[31:0] and missCount[31:0], reset to 0.
  - hitCount += 1 on each Idle-cycle read hit.
  - missCount += 1 on each Idle → ReadIssue transition.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header:
  - state encodings (Idle=0, ReadIssue=1, ReadWait=2, WriteIssue=3, WriteWait=4);
  - SET_BITS and tag/index bit-range constants.
- Sub-module cache_way, instantiated twice:
  - holds tag/valid/data arrays for one way;
  - combinational lookup (hit, data);
  - synchronous fill/update port;
  - asynchronous valid clear on rst.
- LRU bits, FSM and the SRAM interface live in cache_controller.

Test Plan:
- Cold read of 0x0000_0100, SRAM model returns 0xDEADBEEF → freeze high 7 cycles, sramRead high exactly 1 cycle, dataOut = 0xDEADBEEF in release cycle.
- Repeat read of 0x0000_0100 → freeze = 0 same cycle, dataOut = 0xDEADBEEF, no sramRead.
- Fill 0x100 and 0x200 (same set 0, tags differ), read 0x100, then miss on 0x300 → 0x200's way evicted; subsequent read of 0x100 hits, read of 0x200 misses.
- Write 0x12345678 to 0x100 (hit) then read 0x100 → sramWrite pulsed once with sramDataIn = 0x12345678, read hits with 0x12345678; write to uncached 0x400 then read 0x400 → misses.
- read and write both high on 0x104 → write path taken (sramWrite pulse, no sramRead).
- Assert rst during ReadWait → freeze = 0, state Idle immediately; prior hit address 0x100 now misses.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared constants and FSM encoding for the two-way write-through word cache.
// Address layout: [1:0] byte offset, [SET_BITS+1:2] set index, [WORD_ADDR_BITS+1:SET_BITS+2] tag.
package cache_controller_pkg;

    localparam int SET_BITS       = 6;
    localparam int WORD_ADDR_BITS = 17;
    localparam int NUM_SETS       = 1 << SET_BITS;
    localparam int TAG_BITS       = WORD_ADDR_BITS - SET_BITS;

    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = SET_BITS + 1;
    localparam int TAG_LSB = SET_BITS + 2;
    localparam int TAG_MSB = WORD_ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_READ_ISSUE  = 3'd1,
        S_READ_WAIT   = 3'd2,
        S_WRITE_ISSUE = 3'd3,
        S_WRITE_WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag/valid/data arrays, combinational lookup and a synchronous fill port.
// Valid bits clear asynchronously on rst; tag and data contents are don't-care while invalid.
module cache_way
    import cache_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] i_idx,
    input  logic [TAG_BITS-1:0] i_tag,
    output logic                o_valid,
    output logic                o_hit,
    output logic [31:0]         o_data,
    input  logic                i_wr_en,
    input  logic [31:0]         i_wr_data
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_BITS-1:0] r_tag  [NUM_SETS];
    logic [31:0]         r_data [NUM_SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // A write hit rewrites the same tag, so fill and update share one port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_wr_data;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
    assign o_data  = r_data[i_idx];

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate word cache in front of the SRAM controller.
// Optional `CACHE_STATS_EN adds hitCount/missCount output counters.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        freeze,
    output logic        sramRead,
    output logic        sramWrite,
    output logic [31:0] sramAddress,
    output logic [31:0] sramDataIn,
    input  logic [31:0] sramDataOut,
`ifdef CACHE_STATS_EN
    output logic [31:0] hitCount,
    output logic [31:0] missCount,
`endif
    input  logic        sramFreeze
);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_data_out;
    logic [NUM_SETS-1:0] r_lru;

    logic [SET_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_valid0, w_valid1, w_hit0, w_hit1, w_hit;
    logic [31:0]         w_data0, w_data1, w_hit_data;
    logic                w_hit_way, w_victim;
    logic                w_latch, w_fill_en, w_fill_way, w_lru_we, w_lru_val;
    logic                w_rd_hit, w_rd_miss;
    logic [31:0]         w_fill_data, w_data_out;

    // Idle looks up the live request; the wait states look up the latched one for the fill.
    assign w_idx = (r_state == S_IDLE) ? address[IDX_MSB:IDX_LSB] : r_addr[IDX_MSB:IDX_LSB];
    assign w_tag = (r_state == S_IDLE) ? address[TAG_MSB:TAG_LSB] : r_addr[TAG_MSB:TAG_LSB];

    cache_way u_way0 (
        .clk       (clk),
        .rst       (rst),
        .i_idx     (w_idx),
        .i_tag     (w_tag),
        .o_valid   (w_valid0),
        .o_hit     (w_hit0),
        .o_data    (w_data0),
        .i_wr_en   (w_fill_en && !w_fill_way),
        .i_wr_data (w_fill_data)
    );

    cache_way u_way1 (
        .clk       (clk),
        .rst       (rst),
        .i_idx     (w_idx),
        .i_tag     (w_tag),
        .o_valid   (w_valid1),
        .o_hit     (w_hit1),
        .o_data    (w_data1),
        .i_wr_en   (w_fill_en && w_fill_way),
        .i_wr_data (w_fill_data)
    );

    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = !w_hit0;
    assign w_hit_data = w_hit0 ? w_data0 : w_data1;
    assign w_victim   = !w_valid0 ? 1'b0 : (!w_valid1 ? 1'b1 : r_lru[w_idx]);

    always_comb begin
        w_next      = r_state;
        freeze      = 1'b0;
        sramRead    = 1'b0;
        sramWrite   = 1'b0;
        w_latch     = 1'b0;
        w_fill_en   = 1'b0;
        w_fill_way  = 1'b0;
        w_fill_data = dataIn;
        w_lru_we    = 1'b0;
        w_lru_val   = 1'b0;
        w_data_out  = r_data_out;
        w_rd_hit    = 1'b0;
        w_rd_miss   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (write) begin
                    freeze  = 1'b1;
                    w_latch = 1'b1;
                    w_next  = S_WRITE_ISSUE;
                    if (w_hit) begin
                        w_fill_en  = 1'b1;
                        w_fill_way = w_hit_way;
                        w_lru_we   = 1'b1;
                        w_lru_val  = !w_hit_way;
                    end
                end else if (read) begin
                    if (w_hit) begin
                        w_data_out = w_hit_data;
                        w_lru_we   = 1'b1;
                        w_lru_val  = !w_hit_way;
                        w_rd_hit   = 1'b1;
                    end else begin
                        freeze    = 1'b1;
                        w_latch   = 1'b1;
                        w_rd_miss = 1'b1;
                        w_next    = S_READ_ISSUE;
                    end
                end
            end
            S_READ_ISSUE: begin
                freeze   = 1'b1;
                sramRead = 1'b1;
                w_next   = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                if (sramFreeze) begin
                    freeze = 1'b1;
                end else begin
                    w_next      = S_IDLE;
                    w_data_out  = sramDataOut;
                    w_fill_en   = 1'b1;
                    w_fill_way  = w_victim;
                    w_fill_data = sramDataOut;
                    w_lru_we    = 1'b1;
                    w_lru_val   = !w_victim;
                end
            end
            S_WRITE_ISSUE: begin
                freeze    = 1'b1;
                sramWrite = 1'b1;
                w_next    = S_WRITE_WAIT;
            end
            S_WRITE_WAIT: begin
                if (sramFreeze) begin
                    freeze = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_lru      <= '0;
        end else begin
            r_state    <= w_next;
            r_data_out <= w_data_out;
            if (w_latch) begin
                r_addr  <= address;
                r_wdata <= dataIn;
            end
            if (w_lru_we) begin
                r_lru[w_idx] <= w_lru_val;
            end
        end
    end

    assign dataOut     = w_data_out;
    assign sramAddress = r_addr;
    assign sramDataIn  = r_wdata;

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_rd_hit)  r_hit_count  <= r_hit_count + 32'd1;
            if (w_rd_miss) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hitCount  = r_hit_count;
    assign missCount = r_miss_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_rd_hit ^ w_rd_miss;
`endif

endmodule
